// File: rtl/bcd_to_bin_16.sv
// bcd_to_bin_16: sequential 5-digit BCD to 16-bit binary converter.
// Uses reverse double-dabble with one shift step per clock.
// Latency is a constant 16 cycles from the accepting start edge to done.
// The result saturates to 16'hFFFF when the value exceeds 65535.
// The result is forced to zero when any input digit is greater than 9.
module bcd_to_bin_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d4,
    input  logic [3:0]  d3,
    input  logic [3:0]  d2,
    input  logic [3:0]  d1,
    input  logic [3:0]  d0,
    output logic        busy,
    output logic        done,
    output logic [15:0] bin,
    output logic        err_digit,
    output logic        err_ovf
);

    localparam int unsigned BCD_W  = 20;
    localparam int unsigned BIN_W  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned NDIG   = 5;
    localparam int unsigned STEPS  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_step;
    logic [BIN_W-1:0]       bin_step;
    logic                   digit_bad;

    // One reverse double-dabble step: joint right shift, then -3 on nibbles >= 8
    always_comb begin
        shifted  = {bcd_q, bin_q} >> 1;
        bin_step = shifted[BIN_W-1:0];
        bcd_step = shifted[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_step[4*i +: 4] >= 4'd8) begin
                bcd_step[4*i +: 4] = bcd_step[4*i +: 4] - 4'd3;
            end
        end
    end

    // Any digit outside 0..9 marks the request as invalid
    always_comb begin
        digit_bad = (d4 > 4'd9) || (d3 > 4'd9) || (d2 > 4'd9) ||
                    (d1 > 4'd9) || (d0 > 4'd9);
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin       <= '0;
            err_digit <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bcd_q     <= {d4, d3, d2, d1, d0};
                        bin_q     <= '0;
                        cnt       <= CNT_W'(STEPS);
                        err_digit <= digit_bad;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_step;
                    bin_q <= bin_step;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                        if (err_digit) begin
                            bin     <= '0;
                            err_ovf <= 1'b0;
                        end else if (bcd_step != '0) begin
                            bin     <= '1;
                            err_ovf <= 1'b1;
                        end else begin
                            bin     <= bin_step;
                            err_ovf <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_16.sv
// tb_bcd_to_bin_16: randomized self-checking bench for bcd_to_bin_16.
// Expected results come from an arithmetic decimal model.
module tb_bcd_to_bin_16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  d4 = '0, d3 = '0, d2 = '0, d1 = '0, d0 = '0;
    logic        busy, done, err_digit, err_ovf;
    logic [15:0] bin;

    int nchk = 0;
    int nbad = 0;

    logic [15:0] prev_bin  = '0;
    logic        prev_errd = 1'b0;
    logic        prev_ovf  = 1'b0;

    bcd_to_bin_16 dut (
        .clk(clk), .rst(rst), .start(start),
        .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .busy(busy), .done(done), .bin(bin),
        .err_digit(err_digit), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decimal reference: value from digit weights, then error / saturation rules
    task automatic model(input int a, input int b, input int c, input int d, input int e,
                         output logic [15:0] eb, output logic ed, output logic eo);
        int val;
        ed  = (a > 9) || (b > 9) || (c > 9) || (d > 9) || (e > 9);
        val = a * 10000 + b * 1000 + c * 100 + d * 10 + e;
        if (ed) begin
            eb = 16'h0000; eo = 1'b0;
        end else if (val > 65535) begin
            eb = 16'hFFFF; eo = 1'b1;
        end else begin
            eb = 16'(val); eo = 1'b0;
        end
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d, input int e);
        d4 = 4'(a); d3 = 4'(b); d2 = 4'(c); d1 = 4'(d); d0 = 4'(e);
    endtask

    // One conversion; optionally pokes a second start mid-conversion
    task automatic convert(input int a, input int b, input int c, input int d, input int e,
                           input bit poke);
        logic [15:0] eb;
        logic ed, eo;
        int lat, bcyc;
        model(a, b, c, d, e, eb, ed, eo);
        @(negedge clk);
        set_digits(a, b, c, d, e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_accept", 32'(busy), 32'd1);
        check("errd_at_accept", 32'(err_digit), 32'(ed));
        check("bin_held_at_accept", 32'(bin), 32'(prev_bin));
        check("ovf_held_at_accept", 32'(err_ovf), 32'(prev_ovf));
        set_digits(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)));
        lat = 0;
        bcyc = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcyc++;
            if (poke && lat == 5) begin
                start = 1'b1;
                set_digits(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                           int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                           int'($urandom_range(0, 9)));
            end
            if (poke && lat == 6) start = 1'b0;
        end
        check("latency", 32'(lat), 32'd16);
        check("busy_cycles", 32'(bcyc), 32'd15);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("bin", 32'(bin), 32'(eb));
        check("err_digit", 32'(err_digit), 32'(ed));
        check("err_ovf", 32'(err_ovf), 32'(eo));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("no_relaunch", 32'(busy), 32'd0);
        check("bin_hold", 32'(bin), 32'(eb));
        prev_bin = eb; prev_errd = ed; prev_ovf = eo;
    endtask

    initial begin
        logic [15:0] ea, eb2;
        logic eda, eoa, edb, eob;
        int nd, t1, t2, v, mode;

        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_errd", 32'(err_digit), 32'd0);
        check("rst_ovf", 32'(err_ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        convert(1, 2, 3, 4, 5, 1'b0);
        convert(6, 5, 5, 3, 5, 1'b0);
        convert(0, 0, 0, 0, 0, 1'b0);
        convert(6, 5, 5, 3, 6, 1'b0);
        convert(9, 9, 9, 9, 9, 1'b0);
        convert(0, 0, 0, 10, 1, 1'b0);
        convert(1, 2, 3, 4, 5, 1'b1);

        // Reset mid-conversion aborts without done; start during reset ignored
        @(negedge clk);
        set_digits(1, 2, 3, 4, 5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bin", 32'(bin), 32'd0);
        check("abort_errd", 32'(err_digit), 32'd0);
        check("abort_ovf", 32'(err_ovf), 32'd0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        check("abort_no_activity", 32'(nd), 32'd0);
        prev_bin = '0; prev_errd = 1'b0; prev_ovf = 1'b0;
        convert(0, 0, 0, 4, 2, 1'b0);

        // start held high: back-to-back conversions, second picks up new digits
        model(6, 5, 5, 3, 5, ea, eda, eoa);
        model(0, 1, 0, 0, 0, eb2, edb, eob);
        @(negedge clk);
        set_digits(6, 5, 5, 3, 5);
        start = 1'b1;
        nd = 0; t1 = 0; t2 = 0;
        for (int c = 1; c <= 60 && nd < 2; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    t1 = c;
                    check("bb_bin1", 32'(bin), 32'(ea));
                    set_digits(0, 1, 0, 0, 0);
                end else begin
                    t2 = c;
                    check("bb_bin2", 32'(bin), 32'(eb2));
                    check("bb_ovf2", 32'(err_ovf), 32'(eob));
                end
            end
        end
        start = 1'b0;
        check("bb_dones", 32'(nd), 32'd2);
        check("bb_first_latency", 32'(t1), 32'd17);
        check("bb_period_ok", 32'((t2 - t1 == 17) || (t2 - t1 == 18)), 32'd1);
        repeat (3) @(posedge clk);
        prev_bin = eb2; prev_errd = edb; prev_ovf = eob;

        // Randomized conversions
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: v = int'($urandom_range(0, 99999));
                1: v = 65530 + int'($urandom_range(0, 11));
                3: v = int'($urandom_range(0, 65535));
                default: v = -1;
            endcase
            if (v < 0) begin
                convert(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(10, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                convert(v / 10000, (v / 1000) % 10, (v / 100) % 10, (v / 10) % 10, v % 10,
                        1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end

endmodule
